// File: rtl/mm_round_engine_if.sv
// Touch-panel, secret-code and score bundle between the front end and mm_round_engine.
interface mm_round_engine_if #(
  parameter int unsigned NUM_PEGS = 4,
  parameter int unsigned NUM_ROWS = 8
);
  localparam int unsigned CW = 3;
  localparam int unsigned PW = $clog2(NUM_PEGS + 1);
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic [9:0]           touch_x;
  logic [9:0]           touch_y;
  logic                 touch_valid;
  logic [NUM_PEGS*CW-1:0] secret;
  logic                 secret_load;
  logic [NUM_PEGS*CW-1:0] guess;
  logic [RW-1:0]        row;
  logic [PW-1:0]        black;
  logic [PW-1:0]        white;
  logic                 score_valid;
  logic                 busy;
  logic                 game_won;
  logic                 game_lost;

  modport master (
    output touch_x, touch_y, touch_valid, secret, secret_load,
    input  guess, row, black, white, score_valid, busy, game_won, game_lost
  );

  modport slave (
    input  touch_x, touch_y, touch_valid, secret, secret_load,
    output guess, row, black, white, score_valid, busy, game_won, game_lost
  );
endinterface

// File: rtl/mm_round_engine.sv
// Mastermind round controller: touch-driven peg entry plus multi-cycle black/white scoring.
// Optional MM_REPEAT_REJECT_EN: a submit repeating the last scored guess is ignored.
module mm_round_engine #(
  parameter int unsigned NUM_PEGS    = 4,
  parameter int unsigned NUM_COLORS  = 6,
  parameter int unsigned NUM_ROWS    = 8,
  parameter int unsigned CELL_W      = 96,
  parameter int unsigned CELL_H      = 100,
  parameter int unsigned HOLD_CYCLES = 10000000
) (
  input logic clock,
  input logic reset,
  mm_round_engine_if.slave bus
);

  localparam int unsigned CW = 3;
  localparam int unsigned PW = $clog2(NUM_PEGS + 1);
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GW = NUM_PEGS * CW;

  typedef enum logic [2:0] {IDLE, ENTRY, SCORE_B, SCORE_W, RESULT, DONE} stateT;

  stateT         stateQ, stateNext;
  logic [GW-1:0] secretQ, secretD;
  logic [GW-1:0] guessQ, guessD;
  logic [RW-1:0] rowQ, rowD;
  logic [PW-1:0] blackQ, blackD;
  logic [PW-1:0] whiteQ, whiteD;
  logic          scoreValidQ, scoreValidD;
  logic          busyQ, busyD;
  logic          wonQ, wonD;
  logic          lostQ, lostD;
  logic [HW-1:0] holdCntQ, holdCntD;
  logic [PW-1:0] lastCellQ, lastCellD;
  logic          pressLatchQ, pressLatchD;
  logic [PW-1:0] pegIdxQ, pegIdxD;
  logic [CW-1:0] colorIdxQ, colorIdxD;
  logic [PW-1:0] blackAccQ, blackAccD;
  logic [PW-1:0] totalAccQ, totalAccD;
`ifdef MM_REPEAT_REJECT_EN
  logic [GW-1:0] lastGuessQ, lastGuessD;
`endif

  // Number of pegs in a code holding the given colour.
  function automatic logic [PW-1:0] countColor(input logic [GW-1:0] code,
                                               input logic [CW-1:0] color);
    logic [PW-1:0] n;
    n = '0;
    for (int unsigned k = 0; k < NUM_PEGS; k++) begin
      if (code[k*CW +: CW] == color) n = n + PW'(1);
    end
    return n;
  endfunction

  // Out-of-range secret pegs become colour 1 so every code is playable.
  function automatic logic [GW-1:0] sanitize(input logic [GW-1:0] code);
    logic [GW-1:0] s;
    s = code;
    for (int unsigned k = 0; k < NUM_PEGS; k++) begin
      if (code[k*CW +: CW] == '0 || 32'(code[k*CW +: CW]) > NUM_COLORS) begin
        s[k*CW +: CW] = CW'(1);
      end
    end
    return s;
  endfunction

  function automatic logic [CW-1:0] nextColor(input logic [CW-1:0] c);
    return (c == '0 || 32'(c) >= NUM_COLORS) ? CW'(1) : c + CW'(1);
  endfunction

  // Cell decode against the active row band.
  logic [31:0] colFull, yPix, bandLo;
  logic        inBand, cellValid, isSubmit;
  logic [PW-1:0] cellId;

  assign colFull   = 32'(bus.touch_x) / CELL_W;
  assign yPix      = 32'(bus.touch_y);
  assign bandLo    = 32'(rowQ) * CELL_H;
  assign inBand    = (yPix >= bandLo) && (yPix < bandLo + CELL_H);
  assign cellValid = bus.touch_valid && inBand && (colFull <= NUM_PEGS);
  assign isSubmit  = (colFull == NUM_PEGS);
  assign cellId    = PW'(colFull);

  // A press fires once when the same cell has been held for HOLD_CYCLES cycles.
  logic track, sameCell, fire, pegFire, submitFire;

  assign track      = (stateQ == ENTRY) && cellValid && !pressLatchQ;
  assign sameCell   = (holdCntQ == '0) || (cellId == lastCellQ);
  assign fire       = track && sameCell && (holdCntQ == HW'(HOLD_CYCLES - 1));
  assign pegFire    = fire && !isSubmit;
  assign submitFire = fire && isSubmit;

  logic allSet, repeatHit, submitOk;

  always_comb begin
    allSet = 1'b1;
    for (int unsigned k = 0; k < NUM_PEGS; k++) begin
      if (guessQ[k*CW +: CW] == '0) allSet = 1'b0;
    end
  end

`ifdef MM_REPEAT_REJECT_EN
  assign repeatHit = (guessQ == lastGuessQ);
`else
  assign repeatHit = 1'b0;
`endif

  assign submitOk = allSet && !repeatHit;

  // Per-step scoring terms: current peg match and current colour overlap.
  logic          pegMatch;
  logic [PW-1:0] guessCnt, secretCnt, colorMin;
  logic          lastPeg, lastColor;

  always_comb begin
    pegMatch = 1'b0;
    for (int unsigned k = 0; k < NUM_PEGS; k++) begin
      if (PW'(k) == pegIdxQ) pegMatch = (guessQ[k*CW +: CW] == secretQ[k*CW +: CW]);
    end
    guessCnt  = countColor(guessQ, colorIdxQ);
    secretCnt = countColor(secretQ, colorIdxQ);
    colorMin  = (guessCnt < secretCnt) ? guessCnt : secretCnt;
  end

  assign lastPeg   = (pegIdxQ == PW'(NUM_PEGS - 1));
  assign lastColor = (colorIdxQ == CW'(NUM_COLORS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateNext;
  end

  always_comb begin
    stateNext = stateQ;
    if (bus.secret_load) begin
      stateNext = ENTRY;
    end else begin
      case (stateQ)
        ENTRY:   if (submitFire && submitOk) stateNext = SCORE_B;
        SCORE_B: if (lastPeg) stateNext = SCORE_W;
        SCORE_W: if (lastColor) stateNext = RESULT;
        RESULT:  stateNext = (blackQ == PW'(NUM_PEGS) || rowQ == '0) ? DONE : ENTRY;
        default: stateNext = stateQ;
      endcase
    end
  end

  always_comb begin
    secretD     = secretQ;
    guessD      = guessQ;
    rowD        = rowQ;
    blackD      = blackQ;
    whiteD      = whiteQ;
    scoreValidD = 1'b0;
    busyD       = busyQ;
    wonD        = wonQ;
    lostD       = lostQ;
    holdCntD    = '0;
    lastCellD   = lastCellQ;
    pressLatchD = pressLatchQ;
    pegIdxD     = pegIdxQ;
    colorIdxD   = colorIdxQ;
    blackAccD   = blackAccQ;
    totalAccD   = totalAccQ;
`ifdef MM_REPEAT_REJECT_EN
    lastGuessD  = lastGuessQ;
`endif

    if (track && sameCell && !fire) holdCntD = holdCntQ + HW'(1);
    if (track && holdCntQ == '0)    lastCellD = cellId;
    if (fire)                       pressLatchD = 1'b1;
    if (!bus.touch_valid)           pressLatchD = 1'b0;

    if (bus.secret_load) begin
      secretD  = sanitize(bus.secret);
      guessD   = '0;
      rowD     = RW'(NUM_ROWS - 1);
      blackD   = '0;
      whiteD   = '0;
      busyD    = 1'b0;
      wonD     = 1'b0;
      lostD    = 1'b0;
      holdCntD = '0;
`ifdef MM_REPEAT_REJECT_EN
      lastGuessD = '0;
`endif
    end else begin
      case (stateQ)
        ENTRY: begin
          if (pegFire) begin
            for (int unsigned k = 0; k < NUM_PEGS; k++) begin
              if (PW'(k) == cellId) guessD[k*CW +: CW] = nextColor(guessQ[k*CW +: CW]);
            end
          end else if (submitFire && submitOk) begin
            busyD     = 1'b1;
            pegIdxD   = '0;
            blackAccD = '0;
          end
        end
        SCORE_B: begin
          blackAccD = blackAccQ + PW'(pegMatch);
          pegIdxD   = pegIdxQ + PW'(1);
          if (lastPeg) begin
            colorIdxD = CW'(1);
            totalAccD = '0;
          end
        end
        SCORE_W: begin
          totalAccD = totalAccQ + colorMin;
          colorIdxD = colorIdxQ + CW'(1);
          // Publish on the last colour so the score is visible during RESULT.
          if (lastColor) begin
            blackD      = blackAccQ;
            whiteD      = totalAccQ + colorMin - blackAccQ;
            scoreValidD = 1'b1;
            busyD       = 1'b0;
          end
        end
        RESULT: begin
`ifdef MM_REPEAT_REJECT_EN
          lastGuessD = guessQ;
`endif
          if (blackQ == PW'(NUM_PEGS)) begin
            wonD = 1'b1;
          end else if (rowQ == '0) begin
            lostD = 1'b1;
          end else begin
            rowD   = rowQ - RW'(1);
            guessD = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      secretQ     <= '0;
      guessQ      <= '0;
      rowQ        <= RW'(NUM_ROWS - 1);
      blackQ      <= '0;
      whiteQ      <= '0;
      scoreValidQ <= 1'b0;
      busyQ       <= 1'b0;
      wonQ        <= 1'b0;
      lostQ       <= 1'b0;
      holdCntQ    <= '0;
      lastCellQ   <= '0;
      pressLatchQ <= 1'b0;
      pegIdxQ     <= '0;
      colorIdxQ   <= '0;
      blackAccQ   <= '0;
      totalAccQ   <= '0;
`ifdef MM_REPEAT_REJECT_EN
      lastGuessQ  <= '0;
`endif
    end else begin
      secretQ     <= secretD;
      guessQ      <= guessD;
      rowQ        <= rowD;
      blackQ      <= blackD;
      whiteQ      <= whiteD;
      scoreValidQ <= scoreValidD;
      busyQ       <= busyD;
      wonQ        <= wonD;
      lostQ       <= lostD;
      holdCntQ    <= holdCntD;
      lastCellQ   <= lastCellD;
      pressLatchQ <= pressLatchD;
      pegIdxQ     <= pegIdxD;
      colorIdxQ   <= colorIdxD;
      blackAccQ   <= blackAccD;
      totalAccQ   <= totalAccD;
`ifdef MM_REPEAT_REJECT_EN
      lastGuessQ  <= lastGuessD;
`endif
    end
  end

  assign bus.guess       = guessQ;
  assign bus.row         = rowQ;
  assign bus.black       = blackQ;
  assign bus.white       = whiteQ;
  assign bus.score_valid = scoreValidQ;
  assign bus.busy        = busyQ;
  assign bus.game_won    = wonQ;
  assign bus.game_lost   = lostQ;

endmodule

// File: tb/tb_mm_round_engine.sv
// Self-checking bench for mm_round_engine with a code-level Mastermind reference model.
module tb_mm_round_engine;

  localparam int NP   = 4;
  localparam int NC   = 6;
  localparam int NR   = 8;
  localparam int CWX  = 96;
  localparam int CHY  = 100;
  localparam int HOLD = 4;

  logic clock = 1'b0;
  logic reset;

  mm_round_engine_if #(.NUM_PEGS(NP), .NUM_ROWS(NR)) bus ();

  mm_round_engine #(
    .NUM_PEGS(NP), .NUM_COLORS(NC), .NUM_ROWS(NR),
    .CELL_W(CWX), .CELL_H(CHY), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int nPass = 0;
  int nTotal = 0;
  int ms[NP];
  int mg[NP];
  int tgt[NP];
  int mrow;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3*NP-1:0] code4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic logic [3*NP-1:0] packGuess();
    logic [3*NP-1:0] r;
    for (int k = 0; k < NP; k++) r[k*3 +: 3] = 3'(mg[k]);
    return r;
  endfunction

  // Reference score: exact position matches, then colour overlap minus blacks.
  task automatic ref_score(output int b, output int w);
    int cg[8];
    int cs[8];
    int total;
    b = 0;
    total = 0;
    for (int c = 0; c < 8; c++) begin cg[c] = 0; cs[c] = 0; end
    for (int k = 0; k < NP; k++) begin
      if (mg[k] == ms[k]) b++;
      cg[mg[k]]++;
      cs[ms[k]]++;
    end
    for (int c = 1; c <= NC; c++) total += (cg[c] < cs[c]) ? cg[c] : cs[c];
    w = total - b;
  endtask

  task automatic load_secret(input logic [3*NP-1:0] raw);
    bus.secret = raw;
    bus.secret_load = 1'b1;
    tick();
    bus.secret_load = 1'b0;
    for (int k = 0; k < NP; k++) begin
      ms[k] = int'(raw[k*3 +: 3]);
      if (ms[k] == 0 || ms[k] > NC) ms[k] = 1;
      mg[k] = 0;
    end
    mrow = NR - 1;
  endtask

  task automatic press(input int col, input int cycles);
    bus.touch_x = 10'(col*CWX + 20);
    bus.touch_y = 10'(mrow*CHY + 30);
    bus.touch_valid = 1'b1;
    repeat (cycles) tick();
    bus.touch_valid = 1'b0;
    tick();
  endtask

  task automatic enter_guess();
    for (int k = 0; k < NP; k++) begin
      for (int i = 0; i < 8 && mg[k] != tgt[k]; i++) begin
        press(k, HOLD);
        mg[k] = (mg[k] == NC) ? 1 : mg[k] + 1;
      end
    end
  endtask

  // Press submit, then wait (bounded) for the score pulse; ends one cycle past it.
  task automatic do_submit(output int lat, output int busyCnt, output int b, output int w,
                           output bit got);
    bus.touch_x = 10'(NP*CWX + 20);
    bus.touch_y = 10'(mrow*CHY + 30);
    bus.touch_valid = 1'b1;
    repeat (HOLD) tick();
    bus.touch_valid = 1'b0;
    busyCnt = 0; got = 1'b0; lat = 0; b = -1; w = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.score_valid) begin
        got = 1'b1; lat = i + 1; b = int'(bus.black); w = int'(bus.white);
      end else begin
        if (bus.busy) busyCnt++;
        tick();
      end
    end
    if (got) tick();
  endtask

  task automatic advance_model(input int b);
    if (b != NP && mrow != 0) begin
      mrow--;
      for (int k = 0; k < NP; k++) mg[k] = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.touch_x = '0; bus.touch_y = '0; bus.touch_valid = 1'b0;
    bus.secret = '0; bus.secret_load = 1'b0;
    mrow = NR - 1;
    for (int k = 0; k < NP; k++) mg[k] = 0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    nTotal++; if (bus.guess !== '0) $display("FAIL reset_guess: got %0h expected 0", bus.guess); else nPass++;
    nTotal++; if (bus.row !== 3'(NR-1)) $display("FAIL reset_row: got %0d expected %0d", bus.row, NR-1); else nPass++;
    nTotal++; if (bus.black !== '0 || bus.white !== '0) $display("FAIL reset_score: got %0d/%0d expected 0/0", bus.black, bus.white); else nPass++;
    nTotal++; if (bus.score_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL reset_flags: got sv=%b busy=%b expected 0/0", bus.score_valid, bus.busy); else nPass++;
    nTotal++; if (bus.game_won !== 1'b0 || bus.game_lost !== 1'b0) $display("FAIL reset_game: got won=%b lost=%b expected 0/0", bus.game_won, bus.game_lost); else nPass++;
    press(0, 6);
    nTotal++; if (bus.guess !== '0) $display("FAIL idle_ignores_touch: got %0h expected 0", bus.guess); else nPass++;
  endtask

  task automatic test_hold_once();
    load_secret(code4(2, 6, 5, 2));
    nTotal++; if (bus.row !== 3'(NR-1) || bus.guess !== '0) $display("FAIL load_state: got row=%0d guess=%0h expected %0d/0", bus.row, bus.guess, NR-1); else nPass++;
    bus.touch_x = 10'(20); bus.touch_y = 10'(mrow*CHY + 30); bus.touch_valid = 1'b1;
    repeat (HOLD-1) tick();
    nTotal++; if (bus.guess !== '0) $display("FAIL hold_short: got %0h expected 0", bus.guess); else nPass++;
    tick();
    nTotal++; if (bus.guess !== 12'h001) $display("FAIL hold_fire: got %0h expected 001", bus.guess); else nPass++;
    repeat (20) tick();
    nTotal++; if (bus.guess !== 12'h001) $display("FAIL hold_once: got %0h expected 001", bus.guess); else nPass++;
    bus.touch_valid = 1'b0; tick();
    bus.touch_valid = 1'b1;
    repeat (HOLD) tick();
    nTotal++; if (bus.guess !== 12'h002) $display("FAIL rearm_fire: got %0h expected 002", bus.guess); else nPass++;
    bus.touch_valid = 1'b0; tick();
    mg[0] = 2;
    // Moving between cells mid-hold must not fire either cell.
    bus.touch_x = 10'(CWX + 20); bus.touch_valid = 1'b1;
    repeat (2) tick();
    bus.touch_x = 10'(2*CWX + 20);
    repeat (2) tick();
    bus.touch_valid = 1'b0; tick();
    nTotal++; if (bus.guess !== packGuess()) $display("FAIL cell_change: got %0h expected %0h", bus.guess, packGuess()); else nPass++;
    bus.touch_x = 10'(3*CWX + 20); bus.touch_y = 10'((mrow-1)*CHY + 30); bus.touch_valid = 1'b1;
    repeat (6) tick();
    bus.touch_valid = 1'b0; tick();
    nTotal++; if (bus.guess !== packGuess()) $display("FAIL out_of_band: got %0h expected %0h", bus.guess, packGuess()); else nPass++;
  endtask

  task automatic test_win();
    int lat, bc, b, w, eb, ew;
    bit got;
    tgt = '{2, 6, 5, 2};
    enter_guess();
    nTotal++; if (bus.guess !== packGuess()) $display("FAIL win_entry: got %0h expected %0h", bus.guess, packGuess()); else nPass++;
    ref_score(eb, ew);
    do_submit(lat, bc, b, w, got);
    nTotal++; if (!got || lat != NP+NC+1) $display("FAIL win_latency: got %0d (seen=%b) expected %0d", lat, got, NP+NC+1); else nPass++;
    nTotal++; if (bc != NP+NC) $display("FAIL win_busy_cycles: got %0d expected %0d", bc, NP+NC); else nPass++;
    nTotal++; if (b != eb || w != ew) $display("FAIL win_score: got %0d/%0d expected %0d/%0d", b, w, eb, ew); else nPass++;
    advance_model(eb);
    nTotal++; if (bus.game_won !== 1'b1 || bus.score_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL win_flags: got won=%b sv=%b busy=%b expected 1/0/0", bus.game_won, bus.score_valid, bus.busy); else nPass++;
    press(0, 6);
    nTotal++; if (bus.guess !== packGuess() || bus.row !== 3'(mrow) || bus.game_lost !== 1'b0) $display("FAIL done_ignores_touch: got guess=%0h row=%0d expected %0h/%0d", bus.guess, bus.row, packGuess(), mrow); else nPass++;
  endtask

  task automatic test_white();
    int lat, bc, b, w, eb, ew;
    bit got;
    load_secret(code4(1, 1, 2, 2));
    tgt = '{2, 2, 1, 1};
    enter_guess();
    ref_score(eb, ew);
    do_submit(lat, bc, b, w, got);
    nTotal++; if (!got || b != eb || w != ew) $display("FAIL white_score: got %0d/%0d (seen=%b) expected %0d/%0d", b, w, got, eb, ew); else nPass++;
    advance_model(eb);
    nTotal++; if (bus.row !== 3'(mrow) || bus.guess !== '0) $display("FAIL white_next_row: got row=%0d guess=%0h expected %0d/0", bus.row, bus.guess, mrow); else nPass++;
  endtask

  task automatic test_incomplete();
    int lat, bc, b, w, eb, ew;
    bit got;
    load_secret(code4(1, 2, 3, 4));
    tgt = '{3, 0, 4, 5};
    enter_guess();
    nTotal++; if (bus.guess !== packGuess()) $display("FAIL partial_entry: got %0h expected %0h", bus.guess, packGuess()); else nPass++;
    do_submit(lat, bc, b, w, got);
    nTotal++; if (got || bc != 0 || bus.row !== 3'(mrow)) $display("FAIL partial_submit: got seen=%b busy=%0d row=%0d expected 0/0/%0d", got, bc, bus.row, mrow); else nPass++;
    load_secret(code4(1, 2, 3, 4));
    tgt = '{1, 1, 1, 1};
    enter_guess();
    ref_score(eb, ew);
    do_submit(lat, bc, b, w, got);
    nTotal++; if (!got || b != eb || w != ew) $display("FAIL ones_score: got %0d/%0d (seen=%b) expected %0d/%0d", b, w, got, eb, ew); else nPass++;
    advance_model(eb);
  endtask

  task automatic test_random_lose();
    int lat, bc, b, w, eb, ew;
    bit got;
    bit same;
    logic [3*NP-1:0] raw;
    raw = (3*NP)'($urandom);
    load_secret(raw);
    for (int r = 0; r < NR; r++) begin
      same = 1'b1;
      for (int k = 0; k < NP; k++) begin
        tgt[k] = int'($urandom_range(1, NC));
        if (tgt[k] != ms[k]) same = 1'b0;
      end
      if (same) tgt[0] = (tgt[0] % NC) + 1;
      enter_guess();
      nTotal++; if (bus.guess !== packGuess()) $display("FAIL rand_entry: row %0d got %0h expected %0h", mrow, bus.guess, packGuess()); else nPass++;
      ref_score(eb, ew);
      do_submit(lat, bc, b, w, got);
      nTotal++; if (!got || b != eb || w != ew) $display("FAIL rand_score: row %0d got %0d/%0d (seen=%b) expected %0d/%0d", mrow, b, w, got, eb, ew); else nPass++;
      advance_model(eb);
      nTotal++; if (bus.row !== 3'(mrow) || bus.guess !== packGuess()) $display("FAIL rand_after: got row=%0d guess=%0h expected %0d/%0h", bus.row, bus.guess, mrow, packGuess()); else nPass++;
    end
    nTotal++; if (bus.game_lost !== 1'b1 || bus.game_won !== 1'b0) $display("FAIL lost_flag: got lost=%b won=%b expected 1/0", bus.game_lost, bus.game_won); else nPass++;
    press(1, 6);
    nTotal++; if (bus.guess !== packGuess()) $display("FAIL lost_ignores_touch: got %0h expected %0h", bus.guess, packGuess()); else nPass++;
    load_secret((3*NP)'($urandom));
    nTotal++; if (bus.row !== 3'(NR-1) || bus.game_lost !== 1'b0 || bus.guess !== '0 || bus.black !== '0 || bus.white !== '0) $display("FAIL reload_clear: got row=%0d lost=%b guess=%0h b/w=%0d/%0d expected %0d/0/0/0/0", bus.row, bus.game_lost, bus.guess, bus.black, bus.white, NR-1); else nPass++;
    press(0, HOLD);
    nTotal++; if (bus.guess !== 12'h001) $display("FAIL reload_entry: got %0h expected 001", bus.guess); else nPass++;
    mg[0] = 1;
  endtask

  task automatic test_abort();
    int svCnt;
    load_secret(code4(3, 3, 4, 1));
    for (int k = 0; k < NP; k++) tgt[k] = int'($urandom_range(1, NC));
    enter_guess();
    bus.touch_x = 10'(NP*CWX + 20); bus.touch_y = 10'(mrow*CHY + 30); bus.touch_valid = 1'b1;
    repeat (HOLD) tick();
    bus.touch_valid = 1'b0;
    repeat (NP + 1) tick();
    nTotal++; if (bus.busy !== 1'b1) $display("FAIL abort_busy: got %b expected 1", bus.busy); else nPass++;
    bus.secret = (3*NP)'($urandom);
    bus.secret_load = 1'b1;
    tick();
    bus.secret_load = 1'b0;
    for (int k = 0; k < NP; k++) mg[k] = 0;
    mrow = NR - 1;
    nTotal++; if (bus.guess !== '0 || bus.row !== 3'(NR-1) || bus.busy !== 1'b0) $display("FAIL abort_state: got guess=%0h row=%0d busy=%b expected 0/%0d/0", bus.guess, bus.row, bus.busy, NR-1); else nPass++;
    svCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.score_valid === 1'b1) svCnt++;
      tick();
    end
    nTotal++; if (svCnt != 0) $display("FAIL abort_no_score: got %0d pulses expected 0", svCnt); else nPass++;
    press(2, HOLD);
    nTotal++; if (bus.guess !== 12'h040) $display("FAIL abort_entry: got %0h expected 040", bus.guess); else nPass++;
  endtask

  initial begin
    test_reset();
    test_hold_once();
    test_win();
    test_white();
    test_incomplete();
    test_random_lose();
    test_abort();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/mm_round_engine.md
Name: mm_round_engine

Overview:
- Parametrised Mastermind round controller with configurable peg count, colour count and row count.
- Turns debounced touch-panel presses on the active board row into per-peg colour selections, then scores each submitted guess against a loaded secret code (black/white pegs) with a multi-cycle scoring FSM.
- Sits between the touch-coordinate front end (pixel-scaled x/y) and the LCD board renderer and LED status logic.

Parameters:
- NUM_PEGS, 4, code length (2..8).
- NUM_COLORS, 6, colours 1..NUM_COLORS; 0 = empty (2..7).
- NUM_ROWS, 8, guesses per game (1..8).
- CELL_W, 96, cell width in pixels.
- CELL_H, 100, row height in pixels.
- HOLD_CYCLES, 10000000, consecutive in-cell cycles that register a press.
- Derived: CW = 3 (colour field width); PW = $clog2(NUM_PEGS+1); RW = $clog2(NUM_ROWS).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- touch_x  in  10  pixel x, 0..(NUM_PEGS+1)*CELL_W-1
- touch_y  in  10  pixel y
- touch_valid  in  1  panel currently touched
- secret  in  NUM_PEGS*CW  code; peg k at [k*CW+:CW]
- secret_load  in  1  one-cycle strobe; latch secret and start a game
- guess  out  NUM_PEGS*CW  current row entry, same packing as secret
- row  out  RW  active row index (counts down)
- black  out  PW  right colour, right place (last scored row)
- white  out  PW  right colour, wrong place (last scored row)
- score_valid  out  1  one-cycle pulse when black/white update
- busy  out  1  high in SCORE_B/SCORE_W
- game_won  out  1  sticky until next secret_load
- game_lost  out  1  sticky until next secret_load

Behaviour:
- Reset (async, reset=0): state IDLE; guess=0, row=NUM_ROWS-1, black=0, white=0, score_valid=0, busy=0, game_won=0, game_lost=0; hold counter=0; press latch cleared; internal secret=0.
- States: IDLE, ENTRY, SCORE_B, SCORE_W, RESULT, DONE.
- secret_load in any state (including mid-scoring):
  - latch secret; secret pegs with value 0 or >NUM_COLORS are forced to 1;
  - clear guess, black, white, game_won, game_lost; row=NUM_ROWS-1; go to ENTRY next cycle.
- Cell decode:
  - col = touch_x / CELL_W; the active band is row*CELL_H <= touch_y < (row+1)*CELL_H.
  - col < NUM_PEGS is a peg cell; col == NUM_PEGS is the submit cell; anything else is ignored.
- Press detection (ENTRY only):
  - hold counter increments while touch_valid=1 in the same valid cell.
  - Counter clears on release, on a cell change, or on leaving the band.
  - When the counter reaches HOLD_CYCLES-1, the action fires exactly once; no further action until touch_valid=0 for at least one cycle (release re-arm).
- Peg action: guess[col] += 1; NUM_COLORS wraps to 1; 0 goes to 1.
- Submit action:
  - accepted only if every peg is nonzero, otherwise ignored;
  - on accept go to SCORE_B and set busy=1.
- SCORE_B: one peg per cycle, NUM_PEGS cycles; black accumulator += (guess[k]==secret[k]).
- SCORE_W: one colour per cycle, c = 1..NUM_COLORS (NUM_COLORS cycles).
  - total += min(count of c in guess, count of c in secret).
  - White = total - black.
- RESULT (1 cycle):
  - register black and white; score_valid=1; busy=0.
  - If black==NUM_PEGS: game_won=1, go to DONE.
  - Else if row==0: game_lost=1, go to DONE.
  - Else: row-=1, guess=0, go to ENTRY.
- Submit-to-score_valid latency: exactly NUM_PEGS+NUM_COLORS+1 cycles after the accept cycle.
- Touches are ignored in IDLE, SCORE_B, SCORE_W, RESULT and DONE. The hold counter is cleared on entering ENTRY.
- Outputs are registered; guess reflects an update the cycle after the action.

Optional Feature:
- MM_REPEAT_REJECT_EN defined:
  - the module stores the last scored guess;
  - a submit whose guess equals it is ignored (no scoring, stays in ENTRY);
  - the stored guess is cleared on reset and on secret_load.
- Undefined: identical consecutive guesses are scored normally.

Test Plan:
- Defaults, HOLD_CYCLES=4. secret=(2,6,5,2). Hold peg 0 of row 7 for 4 cycles, then keep holding for 20 more cycles -> guess[0]=1 exactly once; after release and a second 4-cycle hold -> guess[0]=2.
- Enter (2,6,5,2), then submit -> busy high for 10 cycles; score_valid pulses on cycle 11 with black=4, white=0; game_won=1; further touches ignored.
- secret=(1,1,2,2), guess=(2,2,1,1) -> black=0, white=4; row goes 7->6; guess cleared to 0.
- Submit with guess=(3,0,4,5) -> ignored, no busy; then secret=(1,2,3,4), guess=(1,1,1,1) -> black=1, white=0.
- Seven wrong guesses, then an eighth wrong guess at row 0 -> game_lost=1, state DONE; secret_load -> row=7, flags clear, ENTRY.
- secret_load asserted during SCORE_W -> scoring aborted, no score_valid, guess=0, row=7.
